alu_share_ctrl: RTL and testbench

- Shares one combinational 32-bit integer ALU (operands data1/data2, 3-bit select, rotate flag; outputs result, zero) between two requesters, e.g. the pipeline EX stage and the cache-switch helper.
- Round-robin arbitration, a valid/ready request handshake, a registered operand stage and a held response with backpressure.
- Sits beside the ALU instance; the ALU is driven only through this block.

---
 rtl/alu_share_ctrl_if.sv | 43 ++++
 rtl/alu_share_ctrl.sv | 118 +++++++++++
 tb/tb_alu_share_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bundle for alu_share_ctrl: two request/response channels
// plus the shared registered result that both requesters observe.
interface alu_share_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 3
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_data1;
    logic [DATA_WIDTH-1:0] req0_data2;
    logic [SEL_WIDTH-1:0]  req0_select;
    logic                  req0_rotate;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_data1;
    logic [DATA_WIDTH-1:0] req1_data2;
    logic [SEL_WIDTH-1:0]  req1_select;
    logic                  req1_rotate;

    logic                  resp0_valid;
    logic                  resp0_ready;
    logic                  resp1_valid;
    logic                  resp1_ready;
    logic [DATA_WIDTH-1:0] resp_result;
    logic                  resp_zero;

    modport master (
        output req0_valid, req0_data1, req0_data2, req0_select, req0_rotate,
        output req1_valid, req1_data1, req1_data2, req1_select, req1_rotate,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_result, resp_zero,
        output resp0_ready, resp1_ready
    );

    modport slave (
        input  req0_valid, req0_data1, req0_data2, req0_select, req0_rotate,
        input  req1_valid, req1_data1, req1_data2, req1_select, req1_rotate,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_result, resp_zero,
        input  resp0_ready, resp1_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters: round-robin grant,
// registered operand stage feeding the ALU, held result until consumed.
module alu_share_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    alu_share_ctrl_if.slave       bus,
    output logic [DATA_WIDTH-1:0] alu_data1,
    output logic [DATA_WIDTH-1:0] alu_data2,
    output logic [SEL_WIDTH-1:0]  alu_select,
    output logic                  alu_rotate,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  last_grant_q;
    logic                  grant_id_q;
    logic                  gnt0;
    logic                  gnt1;
    logic                  resp_take;

    logic [DATA_WIDTH-1:0] opnd_data1_p0;
    logic [DATA_WIDTH-1:0] opnd_data2_p0;
    logic [SEL_WIDTH-1:0]  opnd_select_p0;
    logic                  opnd_rotate_p0;

    logic [DATA_WIDTH-1:0] result_p1;
    logic                  zero_p1;

    // Arbitration: only in IDLE; on contention the requester that did not win last goes.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign resp_take = grant_id_q ? bus.resp1_ready : bus.resp0_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt0 || gnt1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage p0: operands captured at accept; these registers drive the ALU directly.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            opnd_data1_p0  <= '0;
            opnd_data2_p0  <= '0;
            opnd_select_p0 <= '0;
            opnd_rotate_p0 <= 1'b0;
            grant_id_q     <= 1'b0;
            last_grant_q   <= 1'b1;
        end else if (gnt0 || gnt1) begin
            opnd_data1_p0  <= gnt1 ? bus.req1_data1  : bus.req0_data1;
            opnd_data2_p0  <= gnt1 ? bus.req1_data2  : bus.req0_data2;
            opnd_select_p0 <= gnt1 ? bus.req1_select : bus.req0_select;
            opnd_rotate_p0 <= gnt1 ? bus.req1_rotate : bus.req0_rotate;
            grant_id_q     <= gnt1;
            last_grant_q   <= gnt1;
        end
    end

    // Stage p1: ALU output captured at the end of EXEC and held through RESP.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            result_p1 <= '0;
            zero_p1   <= 1'b0;
        end else if (state_q == EXEC) begin
            result_p1 <= alu_result;
            zero_p1   <= alu_zero;
        end
    end

    assign alu_data1       = opnd_data1_p0;
    assign alu_data2       = opnd_data2_p0;
    assign alu_select      = opnd_select_p0;
    assign alu_rotate      = opnd_rotate_p0;

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.resp0_valid = (state_q == RESP) && !grant_id_q;
    assign bus.resp1_valid = (state_q == RESP) &&  grant_id_q;
    assign bus.resp_result = result_p1;
    assign bus.resp_zero   = zero_p1;

    assign busy            = (state_q != IDLE);
    assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with an adder standing in for the ALU.
module tb_alu_share_ctrl;

    logic        CLK;
    logic        RESET;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [2:0]  alu_select;
    logic        alu_rotate;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;
    logic        grant_id;

    int nchk = 0;
    int nerr = 0;

    alu_share_ctrl_if #(.DATA_WIDTH(32), .SEL_WIDTH(3)) bus ();

    alu_share_ctrl #(.DATA_WIDTH(32), .SEL_WIDTH(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_select (alu_select),
        .alu_rotate (alu_rotate),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    assign alu_result = alu_data1 + alu_data2;
    assign alu_zero   = (alu_result == 32'd0);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [2:0] sel, input logic rot);
        bus.req0_valid  = v;
        bus.req0_data1  = d1;
        bus.req0_data2  = d2;
        bus.req0_select = sel;
        bus.req0_rotate = rot;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [2:0] sel, input logic rot);
        bus.req1_valid  = v;
        bus.req1_data1  = d1;
        bus.req1_data2  = d2;
        bus.req1_select = sel;
        bus.req1_rotate = rot;
    endtask

    initial begin
        RESET = 1'b0;
        set_req0(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        set_req1(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        tick();
        tick();

        // Reset state
        settle();
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_resp0_valid", 32'(bus.resp0_valid), 0);
        check("rst_resp1_valid", 32'(bus.resp1_valid), 0);
        check("rst_resp_result", bus.resp_result, 0);
        check("rst_alu_data1", alu_data1, 0);
        RESET = 1'b1;
        tick();

        // Single req0 operation: 3 + 1
        set_req0(1'b1, 32'd3, 32'd1, 3'b001, 1'b1);
        bus.resp0_ready = 1'b1;
        settle();
        check("t1_req0_ready", 32'(bus.req0_ready), 1);
        check("t1_req1_ready", 32'(bus.req1_ready), 0);
        tick();
        bus.req0_valid = 1'b0;
        settle();
        check("t1_exec_busy", 32'(busy), 1);
        check("t1_exec_alu_data1", alu_data1, 3);
        check("t1_exec_alu_select", 32'(alu_select), 1);
        check("t1_exec_alu_rotate", 32'(alu_rotate), 1);
        check("t1_exec_resp0_valid", 32'(bus.resp0_valid), 0);
        tick();
        settle();
        check("t1_resp0_valid", 32'(bus.resp0_valid), 1);
        check("t1_resp1_valid", 32'(bus.resp1_valid), 0);
        check("t1_resp_result", bus.resp_result, 4);
        check("t1_resp_zero", 32'(bus.resp_zero), 0);
        check("t1_grant_id", 32'(grant_id), 0);
        tick();
        settle();
        check("t1_idle_busy", 32'(busy), 0);

        // Round robin from fresh reset: expect 0,1,0,1, three cycles each
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        set_req0(1'b1, 32'd10, 32'd5, 3'd0, 1'b0);
        set_req1(1'b1, 32'd100, 32'd20, 3'd0, 1'b0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            logic exp_k;
            exp_k = logic'(op % 2);
            settle();
            check($sformatf("rr%0d_req0_ready", op), 32'(bus.req0_ready), 32'(!exp_k));
            check($sformatf("rr%0d_req1_ready", op), 32'(bus.req1_ready), 32'(exp_k));
            tick();
            settle();
            check($sformatf("rr%0d_exec_readies", op), 32'(bus.req0_ready | bus.req1_ready), 0);
            tick();
            settle();
            check($sformatf("rr%0d_grant_id", op), 32'(grant_id), 32'(exp_k));
            check($sformatf("rr%0d_resp_valid", op),
                  32'(exp_k ? bus.resp1_valid : bus.resp0_valid), 1);
            check($sformatf("rr%0d_other_valid", op),
                  32'(exp_k ? bus.resp0_valid : bus.resp1_valid), 0);
            check($sformatf("rr%0d_resp_result", op), bus.resp_result, exp_k ? 32'd120 : 32'd15);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Backpressure on requester 1 with a zero result; req0 waits
        set_req1(1'b1, 32'd0, 32'd0, 3'd0, 1'b0);
        bus.resp1_ready = 1'b0;
        settle();
        check("bp_req1_ready", 32'(bus.req1_ready), 1);
        tick();
        bus.req1_valid = 1'b0;
        set_req0(1'b1, 32'd3, 32'd1, 3'd0, 1'b0);
        settle();
        check("bp_exec_req0_ready", 32'(bus.req0_ready), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("bp%0d_resp1_valid", i), 32'(bus.resp1_valid), 1);
            check($sformatf("bp%0d_resp0_valid", i), 32'(bus.resp0_valid), 0);
            check($sformatf("bp%0d_resp_result", i), bus.resp_result, 0);
            check($sformatf("bp%0d_resp_zero", i), 32'(bus.resp_zero), 1);
            check($sformatf("bp%0d_req0_ready", i), 32'(bus.req0_ready), 0);
            tick();
        end
        bus.resp1_ready = 1'b1;
        settle();
        check("bp_consume_req0_ready", 32'(bus.req0_ready), 0);
        tick();
        bus.resp1_ready = 1'b0;
        settle();
        check("bp_idle_req0_ready", 32'(bus.req0_ready), 1);
        check("bp_idle_resp1_valid", 32'(bus.resp1_valid), 0);

        // Operand change after accept must not disturb the operation
        tick();
        bus.req0_data1 = 32'd7;
        bus.req0_valid = 1'b0;
        settle();
        check("hold_alu_data1", alu_data1, 3);
        check("hold_grant_id", 32'(grant_id), 0);
        tick();
        settle();
        check("hold_resp0_valid", 32'(bus.resp0_valid), 1);
        check("hold_resp_result", bus.resp_result, 4);
        tick();

        // Reset during EXEC discards the operation; req0 then wins first
        set_req0(1'b1, 32'd3, 32'd1, 3'd0, 1'b0);
        set_req1(1'b1, 32'd100, 32'd20, 3'd0, 1'b0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        settle();
        check("rx_req1_ready", 32'(bus.req1_ready), 1);
        tick();
        RESET = 1'b0;
        settle();
        check("rx_exec_busy", 32'(busy), 1);
        tick();
        RESET = 1'b1;
        settle();
        check("rx_busy", 32'(busy), 0);
        check("rx_resp0_valid", 32'(bus.resp0_valid), 0);
        check("rx_resp1_valid", 32'(bus.resp1_valid), 0);
        check("rx_resp_result", bus.resp_result, 0);
        check("rx_grant_id", 32'(grant_id), 0);
        check("rx_req0_ready", 32'(bus.req0_ready), 1);
        check("rx_req1_ready", 32'(bus.req1_ready), 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        check("rx_exec_grant_id", 32'(grant_id), 0);
        tick();
        settle();
        check("rx_resp0_valid_after", 32'(bus.resp0_valid), 1);
        check("rx_resp_result_after", bus.resp_result, 4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
